// File: rtl/ipv4_hdr_check_if.sv
// Stream and status bundle for the ingress IPv4 header checker.
// The slave modport is the checker's view; master is the driver/monitor view.
interface ipv4_hdr_check_if #(
    parameter int unsigned PHIT_SIZE = 512
) ();
    localparam int unsigned KEEP_W = PHIT_SIZE / 8;

    logic [PHIT_SIZE-1:0] tdata_in;
    logic [KEEP_W-1:0]    tkeep_in;
    logic                 tvalid_in;
    logic                 tlast_in;

    logic [PHIT_SIZE-1:0] tdata_out;
    logic [KEEP_W-1:0]    tkeep_out;
    logic                 tvalid_out;
    logic                 tlast_out;

    logic                 hdr_valid;
    logic                 hdr_ok;
    logic [15:0]          pkt_len;
    logic [31:0]          pkt_cnt;
    logic [31:0]          bad_cnt;

    modport slave (
        input  tdata_in, tkeep_in, tvalid_in, tlast_in,
        output tdata_out, tkeep_out, tvalid_out, tlast_out,
        output hdr_valid, hdr_ok, pkt_len, pkt_cnt, bad_cnt
    );

    modport master (
        output tdata_in, tkeep_in, tvalid_in, tlast_in,
        input  tdata_out, tkeep_out, tvalid_out, tlast_out,
        input  hdr_valid, hdr_ok, pkt_len, pkt_cnt, bad_cnt
    );
endinterface

// File: rtl/ipv4_hdr_check.sv
// Ingress IPv4 header checker: pipelined checksum on the first beat of each
// packet, 6-cycle stream pass-through, verdict/length reporting and optional drop.
module ipv4_hdr_check #(
    parameter int unsigned PHIT_SIZE = 512,
    parameter bit          DROP_BAD  = 1'b0
) (
    input logic               clk,
    input logic               rst,
    ipv4_hdr_check_if.slave   bus
);
    localparam int unsigned KEEP_W = PHIT_SIZE / 8;
    localparam int unsigned DEPTH  = 5;

    typedef enum logic {SOF = 1'b0, BODY = 1'b1} state_t;

    state_t state, state_nxt;
    logic   sof_c;

    logic [15:0]          w_c [10];
    logic [16:0]          s1 [5];
    logic [17:0]          s2 [3];
    logic [18:0]          s3 [2];
    logic [19:0]          s4;
    logic [16:0]          s5;

    logic                 sof_p   [DEPTH];
    logic [7:0]           ver_p   [DEPTH];
    logic [15:0]          len_p   [DEPTH];
    logic [PHIT_SIZE-1:0] data_p  [DEPTH];
    logic [KEEP_W-1:0]    keep_p  [DEPTH];
    logic                 valid_p [DEPTH];
    logic                 last_p  [DEPTH];

    logic                 drop;
    logic [31:0]          pkt_cnt_q;
    logic [31:0]          bad_cnt_q;
    logic [15:0]          fold2_c;
    logic                 ok_c;
    logic                 drop_eff_c;

    // Packet framing: state register
    always_ff @(posedge clk) begin
        if (rst) state <= SOF;
        else     state <= state_nxt;
    end

    // Packet framing: next state
    always_comb begin
        state_nxt = state;
        case (state)
            SOF:     if (bus.tvalid_in && !bus.tlast_in) state_nxt = BODY;
            BODY:    if (bus.tvalid_in &&  bus.tlast_in) state_nxt = SOF;
            default: state_nxt = SOF;
        endcase
    end

    // Packet framing: first-beat strobe
    always_comb begin
        sof_c = (state == SOF) && bus.tvalid_in;
    end

    // Ten header words as seen on the incoming beat
    always_comb begin
        for (int i = 0; i < 10; i++) w_c[i] = bus.tdata_in[112 + 16*i +: 16];
    end

    // Data/sideband pipe and adder tree; tree stages advance only behind a sof beat
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                sof_p[i]   <= 1'b0;
                ver_p[i]   <= '0;
                len_p[i]   <= '0;
                data_p[i]  <= '0;
                keep_p[i]  <= '0;
                valid_p[i] <= 1'b0;
                last_p[i]  <= 1'b0;
            end
            for (int i = 0; i < 5; i++) s1[i] <= '0;
            for (int i = 0; i < 3; i++) s2[i] <= '0;
            for (int i = 0; i < 2; i++) s3[i] <= '0;
            s4 <= '0;
            s5 <= '0;
        end else begin
            sof_p[0]   <= sof_c;
            data_p[0]  <= bus.tdata_in;
            keep_p[0]  <= bus.tkeep_in;
            valid_p[0] <= bus.tvalid_in;
            last_p[0]  <= bus.tlast_in;
            for (int i = 1; i < DEPTH; i++) begin
                sof_p[i]   <= sof_p[i-1];
                data_p[i]  <= data_p[i-1];
                keep_p[i]  <= keep_p[i-1];
                valid_p[i] <= valid_p[i-1];
                last_p[i]  <= last_p[i-1];
                if (sof_p[i-1]) begin
                    ver_p[i] <= ver_p[i-1];
                    len_p[i] <= len_p[i-1];
                end
            end
            if (sof_c) begin
                for (int i = 0; i < 5; i++) s1[i] <= 17'(w_c[2*i]) + 17'(w_c[2*i+1]);
                ver_p[0] <= w_c[0][15:8];
                len_p[0] <= w_c[1];
            end
            if (sof_p[0]) begin
                s2[0] <= 18'(s1[0]) + 18'(s1[1]);
                s2[1] <= 18'(s1[2]) + 18'(s1[3]);
                s2[2] <= 18'(s1[4]);
            end
            if (sof_p[1]) begin
                s3[0] <= 19'(s2[0]) + 19'(s2[1]);
                s3[1] <= 19'(s2[2]);
            end
            if (sof_p[2]) s4 <= 20'(s3[0]) + 20'(s3[1]);
            if (sof_p[3]) s5 <= 17'(s4[15:0]) + 17'(s4[19:16]);
        end
    end

    // Final fold, verdict, and drop decision for the beat entering the output stage
    always_comb begin
        fold2_c    = s5[15:0] + 16'(s5[16]);
        ok_c       = (fold2_c == 16'hFFFF) && (ver_p[DEPTH-1] == 8'h45) &&
                     (len_p[DEPTH-1] >= 16'd20);
        drop_eff_c = sof_p[DEPTH-1] ? !ok_c : drop;
    end

    // Output stage, drop latch and saturating counters
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.tdata_out  <= '0;
            bus.tkeep_out  <= '0;
            bus.tvalid_out <= 1'b0;
            bus.tlast_out  <= 1'b0;
            bus.hdr_valid  <= 1'b0;
            bus.hdr_ok     <= 1'b0;
            bus.pkt_len    <= '0;
            drop           <= 1'b0;
            pkt_cnt_q      <= '0;
            bad_cnt_q      <= '0;
        end else begin
            bus.tdata_out  <= data_p[DEPTH-1];
            bus.tkeep_out  <= keep_p[DEPTH-1];
            bus.tlast_out  <= last_p[DEPTH-1];
            bus.tvalid_out <= valid_p[DEPTH-1] && !(DROP_BAD && drop_eff_c);
            bus.hdr_valid  <= sof_p[DEPTH-1];
            bus.hdr_ok     <= sof_p[DEPTH-1] && ok_c;
            if (valid_p[DEPTH-1]) drop <= drop_eff_c && !last_p[DEPTH-1];
            if (sof_p[DEPTH-1]) begin
                bus.pkt_len <= len_p[DEPTH-1];
                if (pkt_cnt_q != 32'hFFFF_FFFF) pkt_cnt_q <= pkt_cnt_q + 32'd1;
                if (!ok_c && bad_cnt_q != 32'hFFFF_FFFF) bad_cnt_q <= bad_cnt_q + 32'd1;
            end
        end
    end

    assign bus.pkt_cnt = pkt_cnt_q;
    assign bus.bad_cnt = bad_cnt_q;
endmodule

// File: tb/tb_ipv4_hdr_check.sv
// Bench for ipv4_hdr_check: two instances (pass and drop mode) share one stimulus
// stream and are compared every cycle against a packet-level reference model.
module tb_ipv4_hdr_check;
    localparam int unsigned PHIT_SIZE = 512;
    localparam int unsigned KEEP_W    = PHIT_SIZE / 8;
    localparam int unsigned CW        = 512;

    typedef struct {
        logic [PHIT_SIZE-1:0] data;
        logic [KEEP_W-1:0]    keep;
        logic                 valid;
        logic                 last;
        logic                 sof;
        logic                 good;
        logic                 dropped;
        logic [15:0]          len;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ipv4_hdr_check_if #(.PHIT_SIZE(PHIT_SIZE)) bus0 ();
    ipv4_hdr_check_if #(.PHIT_SIZE(PHIT_SIZE)) bus1 ();

    assign bus1.tdata_in  = bus0.tdata_in;
    assign bus1.tkeep_in  = bus0.tkeep_in;
    assign bus1.tvalid_in = bus0.tvalid_in;
    assign bus1.tlast_in  = bus0.tlast_in;

    ipv4_hdr_check #(.PHIT_SIZE(PHIT_SIZE), .DROP_BAD(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    ipv4_hdr_check #(.PHIT_SIZE(PHIT_SIZE), .DROP_BAD(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    exp_t        q[$];
    exp_t        zero_e;
    logic        in_pkt;
    logic        cur_bad;
    logic [31:0] m_pkt;
    logic [31:0] m_bad;
    logic [15:0] m_len;

    logic [15:0] vec_words [10] = '{16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011,
                                    16'hB861, 16'hC0A8, 16'h0001, 16'hC0A8, 16'h00C7};

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference verdict: one's-complement sum of all ten words plus field rules
    function automatic logic hdr_good(input logic [PHIT_SIZE-1:0] d);
        int unsigned sum = 0;
        for (int i = 0; i < 10; i++) sum += 32'(d[112 + 16*i +: 16]);
        while (sum > 32'h0000_FFFF) sum = (sum & 32'h0000_FFFF) + (sum >> 16);
        return (sum == 32'h0000_FFFF) && (d[127:120] == 8'h45) && (d[143:128] >= 16'd20);
    endfunction

    function automatic logic [PHIT_SIZE-1:0] rand_data();
        logic [PHIT_SIZE-1:0] d;
        for (int i = 0; i < PHIT_SIZE/32; i++) d[32*i +: 32] = $urandom();
        return d;
    endfunction

    // Random beat carrying W0/W1 as given and a checksum made correct, then XORed with err
    function automatic logic [PHIT_SIZE-1:0] mk_hdr(input logic [15:0] w0, input logic [15:0] w1,
                                                    input logic [15:0] err);
        logic [PHIT_SIZE-1:0] d;
        int unsigned sum = 0;
        d = rand_data();
        d[127:112] = w0;
        d[143:128] = w1;
        for (int i = 0; i < 10; i++) if (i != 5) sum += 32'(d[112 + 16*i +: 16]);
        while (sum > 32'h0000_FFFF) sum = (sum & 32'h0000_FFFF) + (sum >> 16);
        d[207:192] = ~sum[15:0] ^ err;
        return d;
    endfunction

    function automatic logic [PHIT_SIZE-1:0] vec_hdr(input logic [15:0] w5);
        logic [PHIT_SIZE-1:0] d;
        d = rand_data();
        for (int i = 0; i < 10; i++) d[112 + 16*i +: 16] = vec_words[i];
        d[207:192] = w5;
        return d;
    endfunction

    // One clock: advance the model with the sampled beat and compare both instances
    task automatic tick();
        exp_t e;
        exp_t o;
        @(posedge clk);
        o = zero_e;
        if (rst) begin
            q.delete();
            repeat (5) q.push_back(zero_e);
            in_pkt  = 1'b0;
            cur_bad = 1'b0;
            m_pkt   = '0;
            m_bad   = '0;
            m_len   = '0;
        end else begin
            e       = zero_e;
            e.data  = bus0.tdata_in;
            e.keep  = bus0.tkeep_in;
            e.valid = bus0.tvalid_in;
            e.last  = bus0.tlast_in;
            if (bus0.tvalid_in) begin
                if (!in_pkt) begin
                    e.sof   = 1'b1;
                    e.good  = hdr_good(bus0.tdata_in);
                    e.len   = bus0.tdata_in[143:128];
                    cur_bad = !e.good;
                end
                e.dropped = cur_bad;
                in_pkt    = !bus0.tlast_in;
            end
            q.push_back(e);
            o = q.pop_front();
            if (o.sof) begin
                if (m_pkt != 32'hFFFF_FFFF) m_pkt++;
                if (!o.good && m_bad != 32'hFFFF_FFFF) m_bad++;
                m_len = o.len;
            end
        end
        #1;
        check("tdata",       CW'(bus0.tdata_out),  CW'(o.data));
        check("tkeep",       CW'(bus0.tkeep_out),  CW'(o.keep));
        check("tlast",       CW'(bus0.tlast_out),  CW'(o.last));
        check("tvalid",      CW'(bus0.tvalid_out), CW'(o.valid));
        check("hdr_valid",   CW'(bus0.hdr_valid),  CW'(o.sof));
        if (o.sof) check("hdr_ok", CW'(bus0.hdr_ok), CW'(o.good));
        check("pkt_len",     CW'(bus0.pkt_len),    CW'(m_len));
        check("pkt_cnt",     CW'(bus0.pkt_cnt),    CW'(m_pkt));
        check("bad_cnt",     CW'(bus0.bad_cnt),    CW'(m_bad));
        check("drop_tvalid", CW'(bus1.tvalid_out), CW'(o.valid && !o.dropped));
        check("drop_tlast",  CW'(bus1.tlast_out),  CW'(o.last));
        check("drop_hdr_v",  CW'(bus1.hdr_valid),  CW'(o.sof));
        check("drop_pkt",    CW'(bus1.pkt_cnt),    CW'(m_pkt));
        check("drop_bad",    CW'(bus1.bad_cnt),    CW'(m_bad));
    endtask

    task automatic drive(input logic v, input logic [PHIT_SIZE-1:0] d, input logic l);
        bus0.tvalid_in = v;
        bus0.tdata_in  = d;
        bus0.tkeep_in  = v ? KEEP_W'({$urandom(), $urandom()}) : '0;
        bus0.tlast_in  = l;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, rand_data(), 1'b0);
    endtask

    task automatic send_pkt(input logic [PHIT_SIZE-1:0] first, input int beats, input int gap_max);
        for (int b = 0; b < beats; b++) begin
            drive(1'b1, (b == 0) ? first : rand_data(), b == beats - 1);
            if (b < beats - 1 && gap_max > 0) idle($urandom_range(0, gap_max));
        end
    endtask

    function automatic logic [PHIT_SIZE-1:0] rand_hdr();
        int unsigned kind = $urandom_range(0, 5);
        logic [15:0] w0 = {8'h45, 8'($urandom())};
        logic [15:0] w1 = 16'($urandom_range(20, 16'hFFFF));
        case (kind)
            3:       return mk_hdr(w0, w1, 16'($urandom_range(1, 16'hFFFE)));
            4:       return mk_hdr({8'($urandom_range(0, 8'h44)), 8'($urandom())}, w1, 16'h0);
            5:       return mk_hdr(w0, 16'($urandom_range(0, 19)), 16'h0);
            default: return mk_hdr(w0, w1, 16'h0);
        endcase
    endfunction

    initial begin
        zero_e = '{default: '0};
        bus0.tvalid_in = 1'b0;
        bus0.tdata_in  = '0;
        bus0.tkeep_in  = '0;
        bus0.tlast_in  = 1'b0;
        rst = 1'b1;
        drive(1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b0);
        rst = 1'b0;
        idle(3);

        // Known-good header, single beat
        send_pkt(vec_hdr(16'hB861), 1, 0);
        idle(6);
        check("vec_pkt_cnt", CW'(bus0.pkt_cnt), CW'(32'd1));
        check("vec_bad_cnt", CW'(bus0.bad_cnt), CW'(32'd0));
        check("vec_pkt_len", CW'(bus0.pkt_len), CW'(16'h0073));

        // Corrupted checksum
        send_pkt(vec_hdr(16'hB862), 1, 0);
        idle(6);
        check("cks_bad_cnt", CW'(bus0.bad_cnt), CW'(32'd1));

        // Bad 4-beat packet then good 2-beat packet, back to back
        send_pkt(mk_hdr(16'h4500, 16'd100, 16'h0101), 4, 0);
        send_pkt(mk_hdr(16'h4500, 16'd60, 16'h0000), 2, 0);
        idle(6);

        // Version/IHL and minimum length field checks with valid checksums
        send_pkt(mk_hdr(16'h4600, 16'h0073, 16'h0), 1, 0);
        send_pkt(mk_hdr(16'h4500, 16'h0013, 16'h0), 1, 0);
        send_pkt(mk_hdr(16'h4500, 16'h0014, 16'h0), 1, 0);
        idle(6);

        // Good 3-beat packet with two idle cycles between beats
        for (int b = 0; b < 3; b++) begin
            drive(1'b1, (b == 0) ? mk_hdr(16'h4500, 16'd200, 16'h0) : rand_data(), b == 2);
            if (b < 2) idle(2);
        end
        idle(2);

        // Reset in the middle of a packet; the next beat is a new header
        send_pkt(mk_hdr(16'h4500, 16'd300, 16'h0), 1, 0);
        drive(1'b1, mk_hdr(16'h4500, 16'd400, 16'h0), 1'b0);
        drive(1'b1, rand_data(), 1'b0);
        rst = 1'b1;
        drive(1'b1, rand_data(), 1'b0);
        rst = 1'b0;
        drive(1'b1, mk_hdr(16'h4500, 16'd500, 16'h0), 1'b0);
        drive(1'b1, rand_data(), 1'b1);
        idle(6);

        // Randomized traffic
        for (int p = 0; p < 300; p++) begin
            send_pkt(rand_hdr(), $urandom_range(1, 4), ($urandom_range(0, 3) == 0) ? 2 : 0);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 2));
        end
        idle(6);

        // Packet counter saturation
        force dut0.pkt_cnt_q = 32'hFFFF_FFFE;
        force dut1.pkt_cnt_q = 32'hFFFF_FFFE;
        m_pkt = 32'hFFFF_FFFE;
        idle(1);
        release dut0.pkt_cnt_q;
        release dut1.pkt_cnt_q;
        for (int p = 0; p < 3; p++) send_pkt(rand_hdr(), $urandom_range(1, 3), 0);
        idle(6);
        check("sat_pkt_cnt", CW'(bus0.pkt_cnt), CW'(32'hFFFF_FFFF));
        check("sat_pkt_cnt_drop", CW'(bus1.pkt_cnt), CW'(32'hFFFF_FFFF));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ipv4_hdr_check.md
# ipv4_hdr_check

Ingress-side IPv4 header checker for the CGRA stream path. It sits between the packet input port and the CGRA stream-in logic, and mirrors the egress header patcher. On the first beat of every packet it sums the ten 16-bit IPv4 header words with a pipelined adder tree. It then reports whether the header is a valid IPv4 header, extracts the total-length field, and either tags or drops failing packets. The data stream passes through with a fixed 6-cycle delay and has no backpressure.

## Interface
- PHIT_SIZE, 512, stream data width in bits; must be ≥ 272.
- DROP_BAD, 0, when 1, suppress tvalid for every beat of a packet whose header fails.
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- tdata_in  input  PHIT_SIZE  input beat data.
- tkeep_in  input  PHIT_SIZE/8  input byte enables.
- tvalid_in  input  1  beat valid.
- tlast_in  input  1  last beat of packet.
- tdata_out  output  PHIT_SIZE  delayed data.
- tkeep_out  output  PHIT_SIZE/8  delayed byte enables.
- tvalid_out  output  1  delayed valid; gated when DROP_BAD=1.
- tlast_out  output  1  delayed last.
- hdr_valid  output  1  one-cycle pulse, coincident with the first beat of a packet on the output.
- hdr_ok  output  1  header verdict; meaningful only while hdr_valid=1.
- pkt_len  output  16  tdata_in[143:128] of the first beat; held until the next hdr_valid.
- pkt_cnt  output  32  packets seen, saturating.
- bad_cnt  output  32  failing packets, saturating.

## Operation
- Header word layout on the first beat, as contiguous slices:
  - W0=[127:112], W1=[143:128], W2=[159:144], W3=[175:160], W4=[191:176].
  - W5=[207:192] is the checksum; W6..W9=[223:208]..[271:256].
- Input FSM states:
  - SOF (reset state): a beat with tvalid_in=1 is the first beat. It enters the checksum pipeline with sof=1, then the FSM goes to BODY, or stays in SOF if tlast_in=1.
  - BODY: tvalid_in=1 with tlast_in=1 returns the FSM to SOF.
  - tvalid_in=0 cycles hold the state in both SOF and BODY.
- Checksum pipeline, one register stage per step, entered only by sof beats:
  - S1: five 17-bit sums W0+W1, W2+W3, ... W8+W9.
  - S2: three 18-bit sums (a+b, c+d, e).
  - S3: two 19-bit sums.
  - S4: one 20-bit sum.
  - S5: fold to 17 bits, low16 + high4.
  - S6: second fold (low16 + bit16); result compared with 16'hFFFF.
  - No header bits outside W0..W9 affect the result.
- hdr_ok = (folded sum == 16'hFFFF) AND (W0[15:8] == 8'h45) AND (W1 ≥ 16'd20).
- Version/IHL, pkt_len and sof flag are carried in a 6-deep register pipe, aligned with the sum.
- Data path: {tlast, tvalid, tkeep, tdata} pass through a 6-deep register pipe.
- Output-side drop latch:
  - Loaded on the delayed sof beat with !hdr_ok.
  - Cleared after a delayed beat carrying tlast.
  - Only gates tvalid_out when DROP_BAD=1; tdata, tkeep and tlast pass unchanged.
- Counters: pkt_cnt increments on every hdr_valid pulse. bad_cnt increments on every hdr_valid pulse with hdr_ok=0. Both counters stop at 32'hFFFFFFFF.

## Timing
- Latency: an input beat at cycle t appears on the outputs at t+6. hdr_valid and hdr_ok for a packet assert in the same cycle as its first output beat.
- Reset values:
  - All outputs 0.
  - All pipe stages and the sof flag cleared.
  - FSM in SOF; drop latch clear.
  - Beats in flight during reset are discarded, not emitted.
- Reset mid-packet: the remaining beats of that packet arrive in SOF. The first of them is treated as a new header, and its verdict is reported normally.
- Back-to-back packets are supported: a tlast beat at cycle t may be followed by a sof beat at t+1. Throughput is one header per cycle.
- Single-beat packets: the sof beat also carries tlast. The drop latch is loaded and cleared on the same beat, and DROP_BAD still gates that beat.
- Bubbles (tvalid_in=0) propagate unchanged with the same 6-cycle delay. hdr_valid never asserts on a bubble.

## Test plan
- Valid header: W0..W9 = 4500, 0073, 0000, 4000, 4011, B861, C0A8, 0001, C0A8, 00C7, sent as one beat with tlast. Expected at +6: hdr_valid=1, hdr_ok=1, pkt_len=16'h0073, pkt_cnt=1, bad_cnt=0.
- Corrupted checksum: same header with W5=B862, DROP_BAD=0. Expected: hdr_ok=0, bad_cnt=1, tvalid_out still 1 on the beat.
- Drop mode: DROP_BAD=1, bad header on a 4-beat packet, followed back-to-back by a good 2-beat packet. Expected: tvalid_out=0 on all 4 bad beats, 1 on both good beats; bad_cnt=1, pkt_cnt=2.
- Field checks: W0=4600 with the checksum recomputed, and separately W1=0013 with the checksum recomputed. Expected: hdr_ok=0 in both cases.
- Bubbles and reset: a 3-beat good packet with 2 idle cycles between beats. Expected: output gaps preserved exactly and a single hdr_valid. Then assert rst in the middle of a second packet. Expected: all outputs 0 on the next cycle; the next beat is treated as SOF.
- Counter saturation: force pkt_cnt to 32'hFFFFFFFE and send 3 packets. Expected: pkt_cnt ends at 32'hFFFFFFFF.
